// File: rtl/dmi_sba_loader_pkg.sv
// ---------------------------------------------------------------------------
// dmi_sba_loader_pkg
//
// Shared debug-module definitions used by the SBA loader: DMI register
// addresses, DMI request/response op encodings, SBCS field positions, the
// SBCS value written before a burst, and the loader state type.
// ---------------------------------------------------------------------------
package dmi_sba_loader_pkg;

    // DMI register addresses of the system bus access block
    localparam logic [6:0] DMI_ADDR_SBCS       = 7'h38;
    localparam logic [6:0] DMI_ADDR_SBADDRESS0 = 7'h39;
    localparam logic [6:0] DMI_ADDR_SBDATA0    = 7'h3C;

    // DMI request ops
    localparam logic [1:0] DMI_OP_READ  = 2'd1;
    localparam logic [1:0] DMI_OP_WRITE = 2'd2;

    // DMI response ops
    localparam logic [1:0] DMI_RESP_OK     = 2'd0;
    localparam logic [1:0] DMI_RESP_FAILED = 2'd2;
    localparam logic [1:0] DMI_RESP_BUSY   = 2'd3;

    // SBCS field positions
    localparam int SBCS_SBERROR_LSB     = 12;
    localparam int SBCS_SBERROR_MSB     = 14;
    localparam int SBCS_SBBUSY_BIT      = 21;
    localparam int SBCS_SBBUSYERROR_BIT = 22;

    // sbaccess=2 (32-bit), sbautoincrement=1, sbreadondata=1
    localparam logic [31:0] SBCS_INIT_VALUE = 32'h0005_8000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_SBCS,
        ST_WR_ADDR,
        ST_WR_DATA,
        ST_POLL,
        ST_WAIT_RESP,
        ST_DONE,
        ST_ERR
    } loader_state_e;

    // A polled SBCS reports a bus error or a busy-error
    function automatic logic sbcs_has_error(input logic [31:0] sbcs);
        return (sbcs[SBCS_SBERROR_MSB:SBCS_SBERROR_LSB] != 3'b000) ||
               sbcs[SBCS_SBBUSYERROR_BIT];
    endfunction

    // A polled SBCS reports the system bus still busy
    function automatic logic sbcs_is_busy(input logic [31:0] sbcs);
        return sbcs[SBCS_SBBUSY_BIT];
    endfunction

endpackage

// File: rtl/dmi_sba_loader.sv
// ---------------------------------------------------------------------------
// dmi_sba_loader
//
// Streams a block of 32-bit words into system memory through the debug
// module's system bus access registers. For each command it programs SBCS
// for auto-incrementing 32-bit accesses, writes the base address, then
// writes one SBData0 per word, polling SBCS every PollInterval words and
// after the last word.
//
// Ports
//   clk, rst_n                      clock, asynchronous active-low reset
//   cmd_valid/cmd_ready             load command handshake
//   cmd_addr, cmd_len               word-aligned base address, word count
//   wdata_valid/wdata_ready, wdata  payload word stream
//   dmi_req_*                       DMI request channel (one outstanding)
//   dmi_resp_*                      DMI response channel
//   busy, done, err                 status (done is a pulse, err is sticky)
// ---------------------------------------------------------------------------
module dmi_sba_loader
    import dmi_sba_loader_pkg::*;
#(
    parameter int PollInterval = 128,
    parameter int MaxPolls     = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [31:0] cmd_addr,
    input  logic [15:0] cmd_len,
    input  logic        wdata_valid,
    output logic        wdata_ready,
    input  logic [31:0] wdata,
    output logic        dmi_req_valid,
    input  logic        dmi_req_ready,
    output logic [6:0]  dmi_req_addr,
    output logic [1:0]  dmi_req_op,
    output logic [31:0] dmi_req_data,
    input  logic        dmi_resp_valid,
    output logic        dmi_resp_ready,
    input  logic [31:0] dmi_resp_data,
    input  logic [1:0]  dmi_resp_op,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam int IntW  = $clog2(PollInterval + 1);
    localparam int PollW = $clog2(MaxPolls + 1);

    loader_state_e state, state_next;

    logic [31:0]      addr_q;
    logic [15:0]      len_q;
    logic [15:0]      word_cnt;
    logic [IntW-1:0]  interval_cnt;
    logic [PollW-1:0] poll_cnt;
    logic             err_q;

    // The request register holds the single outstanding DMI request; it is
    // only loaded in the issuing states, so it is stable while in WAIT_RESP.
    logic             req_pending;
    logic [6:0]       req_addr_q;
    logic [1:0]       req_op_q;
    logic [31:0]      req_data_q;

    logic             cmd_fire;
    logic             wdata_fire;
    logic             req_fire;
    logic             resp_fire;
    logic             resp_is_poll;
    logic [15:0]      word_cnt_inc;
    logic [IntW-1:0]  interval_inc;
    logic             interval_full;
    logic             last_word;
    logic             all_words_done;
    logic [PollW-1:0] poll_cnt_inc;
    logic             poll_limit;
    logic             poll_error;
    logic             poll_busy;

    assign cmd_fire       = cmd_valid && cmd_ready;
    assign wdata_fire     = wdata_valid && wdata_ready;
    assign req_fire       = dmi_req_valid && dmi_req_ready;
    assign resp_fire      = dmi_resp_valid && dmi_resp_ready;
    assign resp_is_poll   = (req_op_q == DMI_OP_READ);
    assign word_cnt_inc   = word_cnt + 16'd1;
    assign interval_inc   = interval_cnt + IntW'(1);
    assign interval_full  = (interval_inc == IntW'(PollInterval));
    assign last_word      = (word_cnt_inc == len_q);
    assign all_words_done = (word_cnt == len_q);
    assign poll_cnt_inc   = poll_cnt + PollW'(1);
    assign poll_limit     = (poll_cnt_inc == PollW'(MaxPolls));
    assign poll_error     = sbcs_has_error(dmi_resp_data);
    assign poll_busy      = sbcs_is_busy(dmi_resp_data);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. WAIT_RESP decides where to go from the kind of
    // request that was outstanding, recovered from its address and op.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (cmd_fire) begin
                    state_next = (cmd_len == 16'd0) ? ST_DONE : ST_WR_SBCS;
                end
            end
            ST_WR_SBCS, ST_WR_ADDR, ST_POLL: begin
                state_next = ST_WAIT_RESP;
            end
            ST_WR_DATA: begin
                if (wdata_fire) begin
                    state_next = ST_WAIT_RESP;
                end
            end
            ST_WAIT_RESP: begin
                if (resp_fire) begin
                    if (dmi_resp_op == DMI_RESP_BUSY) begin
                        state_next = ST_WAIT_RESP;
                    end else if (dmi_resp_op != DMI_RESP_OK) begin
                        state_next = ST_ERR;
                    end else if (resp_is_poll) begin
                        if (poll_error) begin
                            state_next = ST_ERR;
                        end else if (poll_busy) begin
                            state_next = poll_limit ? ST_ERR : ST_POLL;
                        end else begin
                            state_next = all_words_done ? ST_DONE : ST_WR_DATA;
                        end
                    end else if (req_addr_q == DMI_ADDR_SBCS) begin
                        state_next = ST_WR_ADDR;
                    end else if (req_addr_q == DMI_ADDR_SBADDRESS0) begin
                        state_next = ST_WR_DATA;
                    end else begin
                        state_next = (interval_full || last_word) ? ST_POLL : ST_WR_DATA;
                    end
                end
            end
            ST_DONE, ST_ERR: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Outputs. cmd_ready is gated by rst_n so it stays low while reset is held.
    always_comb begin
        cmd_ready      = rst_n && (state == ST_IDLE);
        wdata_ready    = (state == ST_WR_DATA);
        dmi_req_valid  = req_pending;
        dmi_req_addr   = req_addr_q;
        dmi_req_op     = req_op_q;
        dmi_req_data   = req_data_q;
        dmi_resp_ready = (state == ST_WAIT_RESP) && !req_pending;
        busy           = (state != ST_IDLE);
        done           = (state == ST_DONE);
        err            = err_q;
    end

    // Command latch, request register, counters and sticky error.
    // A busy response re-arms the request register untouched, which is what
    // makes the reissued request identical to the original.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q       <= '0;
            len_q        <= '0;
            word_cnt     <= '0;
            interval_cnt <= '0;
            poll_cnt     <= '0;
            err_q        <= 1'b0;
            req_pending  <= 1'b0;
            req_addr_q   <= '0;
            req_op_q     <= '0;
            req_data_q   <= '0;
        end else begin
            if (cmd_fire) begin
                addr_q       <= cmd_addr;
                len_q        <= cmd_len;
                word_cnt     <= '0;
                interval_cnt <= '0;
                poll_cnt     <= '0;
                err_q        <= 1'b0;
            end

            if ((state != ST_ERR) && (state_next == ST_ERR)) begin
                err_q <= 1'b1;
            end

            case (state)
                ST_WR_SBCS: begin
                    req_pending <= 1'b1;
                    req_addr_q  <= DMI_ADDR_SBCS;
                    req_op_q    <= DMI_OP_WRITE;
                    req_data_q  <= SBCS_INIT_VALUE;
                end
                ST_WR_ADDR: begin
                    req_pending <= 1'b1;
                    req_addr_q  <= DMI_ADDR_SBADDRESS0;
                    req_op_q    <= DMI_OP_WRITE;
                    req_data_q  <= addr_q;
                end
                ST_WR_DATA: begin
                    if (wdata_fire) begin
                        req_pending <= 1'b1;
                        req_addr_q  <= DMI_ADDR_SBDATA0;
                        req_op_q    <= DMI_OP_WRITE;
                        req_data_q  <= wdata;
                    end
                end
                ST_POLL: begin
                    req_pending <= 1'b1;
                    req_addr_q  <= DMI_ADDR_SBCS;
                    req_op_q    <= DMI_OP_READ;
                    req_data_q  <= '0;
                end
                ST_WAIT_RESP: begin
                    if (req_fire) begin
                        req_pending <= 1'b0;
                    end else if (resp_fire) begin
                        if (dmi_resp_op == DMI_RESP_BUSY) begin
                            req_pending <= 1'b1;
                        end else if (dmi_resp_op == DMI_RESP_OK) begin
                            if (resp_is_poll) begin
                                if (!poll_error && poll_busy) begin
                                    poll_cnt <= poll_cnt_inc;
                                end else begin
                                    poll_cnt <= '0;
                                end
                            end else if (req_addr_q == DMI_ADDR_SBDATA0) begin
                                word_cnt     <= word_cnt_inc;
                                interval_cnt <= interval_full ? '0 : interval_inc;
                            end
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmi_sba_loader.sv
// ---------------------------------------------------------------------------
// tb_dmi_sba_loader
//
// Self-checking bench for dmi_sba_loader. A reference model turns each
// command into the list of DMI requests the loader must issue plus the
// responses the responder will give; a monitor compares every accepted DMI
// request against that list, while a driver feeds payload words and a
// responder answers requests with random stalls.
// ---------------------------------------------------------------------------
module tb_dmi_sba_loader;

    localparam int POLL_INTERVAL = 128;
    localparam int MAX_POLLS     = 16;
    localparam int IDLE_LIMIT    = 20000;

    localparam logic [6:0]  A_SBCS   = 7'h38;
    localparam logic [6:0]  A_ADDR   = 7'h39;
    localparam logic [6:0]  A_DATA   = 7'h3C;
    localparam logic [1:0]  OP_RD    = 2'd1;
    localparam logic [1:0]  OP_WR    = 2'd2;
    localparam logic [31:0] SBCS_VAL = 32'h0005_8000;

    typedef struct packed {
        logic [6:0]  addr;
        logic [1:0]  op;
        logic [31:0] data;
    } req_t;

    typedef struct packed {
        logic [1:0]  op;
        logic [31:0] data;
    } resp_t;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_addr;
    logic [15:0] cmd_len;
    logic        wdata_valid;
    logic        wdata_ready;
    logic [31:0] wdata;
    logic        dmi_req_valid;
    logic        dmi_req_ready;
    logic [6:0]  dmi_req_addr;
    logic [1:0]  dmi_req_op;
    logic [31:0] dmi_req_data;
    logic        dmi_resp_valid;
    logic        dmi_resp_ready;
    logic [31:0] dmi_resp_data;
    logic [1:0]  dmi_resp_op;
    logic        busy;
    logic        done;
    logic        err;

    int          checks = 0;
    int          errors = 0;
    req_t        exp_q[$];
    resp_t       plan_q[$];
    logic [31:0] words_q[$];
    int          words_acc;
    int          done_seen;
    int          reads_seen;
    int          reqs_seen = 0;
    bit          timed_out;
    bit          stall_seen = 0;
    logic [40:0] stall_req;
    req_t        mon_exp;

    dmi_sba_loader #(
        .PollInterval(POLL_INTERVAL),
        .MaxPolls    (MAX_POLLS)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_addr      (cmd_addr),
        .cmd_len       (cmd_len),
        .wdata_valid   (wdata_valid),
        .wdata_ready   (wdata_ready),
        .wdata         (wdata),
        .dmi_req_valid (dmi_req_valid),
        .dmi_req_ready (dmi_req_ready),
        .dmi_req_addr  (dmi_req_addr),
        .dmi_req_op    (dmi_req_op),
        .dmi_req_data  (dmi_req_data),
        .dmi_resp_valid(dmi_resp_valid),
        .dmi_resp_ready(dmi_resp_ready),
        .dmi_resp_data (dmi_resp_data),
        .dmi_resp_op   (dmi_resp_op),
        .busy          (busy),
        .done          (done),
        .err           (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    // SBCS content with random bits outside the error and busy fields
    function automatic logic [31:0] benign_sbcs();
        return $urandom & ~32'h0060_7000;
    endfunction

    task automatic push_req(input logic [6:0] a, input logic [1:0] op, input logic [31:0] d,
                            input int busy_reps, input logic [31:0] final_data);
        for (int i = 0; i < busy_reps; i++) begin
            exp_q.push_back('{a, op, d});
            plan_q.push_back('{2'd3, $urandom});
        end
        exp_q.push_back('{a, op, d});
        plan_q.push_back('{2'd0, final_data});
    endtask

    // Reference model: the whole request/response conversation for one
    // command, built from the loading rules with plain counting.
    task automatic build_model(input logic [31:0] addr, input int len,
                               input int busy_at_word, input int busy_reps,
                               input int busy_poll, input int busy_poll_n,
                               input int err_poll, input bit rand_busy,
                               output int e_done, output int e_err, output int e_words);
        int polls;
        int reps;
        int nb;
        exp_q.delete();
        plan_q.delete();
        words_q.delete();
        e_err   = 0;
        e_words = 0;
        polls   = 0;
        for (int k = 0; k < len; k++) words_q.push_back($urandom);
        if (len > 0) begin
            push_req(A_SBCS, OP_WR, SBCS_VAL, 0, $urandom);
            push_req(A_ADDR, OP_WR, addr, 0, $urandom);
            for (int k = 0; k < len; k++) begin
                if (k == busy_at_word) reps = busy_reps;
                else if (rand_busy && $urandom_range(0, 9) == 0) reps = $urandom_range(1, 2);
                else reps = 0;
                push_req(A_DATA, OP_WR, words_q[k], reps, $urandom);
                e_words++;
                if (((k + 1) % POLL_INTERVAL == 0) || (k + 1 == len)) begin
                    if (polls == err_poll) begin
                        push_req(A_SBCS, OP_RD, 32'h0, 0, benign_sbcs() | 32'h0000_2000);
                        e_err = 1;
                        break;
                    end
                    if (polls == busy_poll) nb = busy_poll_n;
                    else nb = rand_busy ? $urandom_range(0, 3) : 0;
                    for (int j = 0; j < nb && j < MAX_POLLS; j++) begin
                        push_req(A_SBCS, OP_RD, 32'h0, 0, benign_sbcs() | 32'h0020_0000);
                    end
                    if (nb >= MAX_POLLS) begin
                        e_err = 1;
                        break;
                    end
                    push_req(A_SBCS, OP_RD, 32'h0, 0, benign_sbcs());
                    polls++;
                end
            end
        end
        e_done = e_err ? 0 : 1;
    endtask

    // Monitor: pops the expected request on every DMI handshake and checks
    // that a stalled request holds its fields.
    always @(negedge clk) begin
        if (!rst_n) begin
            stall_seen = 0;
        end else begin
            if (done) done_seen++;
            if (stall_seen) begin
                check_value("req_stable", {dmi_req_valid, dmi_req_addr, dmi_req_op, dmi_req_data},
                            {1'b1, stall_req});
            end
            if (dmi_req_valid && dmi_req_ready) begin
                reqs_seen++;
                if (dmi_req_op == OP_RD) reads_seen++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_req: got addr 0x%0h op %0d data 0x%0h expected none",
                             dmi_req_addr, dmi_req_op, dmi_req_data);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check_value("req_addr", dmi_req_addr, mon_exp.addr);
                    check_value("req_op", dmi_req_op, mon_exp.op);
                    if (mon_exp.op == OP_WR) check_value("req_data", dmi_req_data, mon_exp.data);
                end
            end
            stall_seen = dmi_req_valid && !dmi_req_ready;
            stall_req  = {dmi_req_addr, dmi_req_op, dmi_req_data};
        end
    end

    // Responder: random ready, then one planned response per accepted request
    initial begin
        resp_t r;
        int    d;
        bit    took;
        dmi_req_ready  = 1'b0;
        dmi_resp_valid = 1'b0;
        dmi_resp_op    = 2'd0;
        dmi_resp_data  = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            dmi_req_ready = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            if (rst_n && dmi_req_valid && dmi_req_ready) begin
                r = (plan_q.size() > 0) ? plan_q.pop_front() : '{2'd0, 32'h0};
                @(posedge clk);
                #1;
                dmi_req_ready = 1'b0;
                d = $urandom_range(0, 2);
                for (int i = 0; i < d; i++) begin
                    @(posedge clk);
                    #1;
                end
                dmi_resp_valid = 1'b1;
                dmi_resp_op    = r.op;
                dmi_resp_data  = r.data;
                took = 0;
                for (int n = 0; n < 1000 && !took; n++) begin
                    @(negedge clk);
                    took = dmi_resp_ready;
                    @(posedge clk);
                    #1;
                end
                dmi_resp_valid = 1'b0;
            end
        end
    end

    task automatic apply_stimulus(input logic [31:0] addr, input int len, output bit ok);
        int n = 0;
        ok = 0;
        @(posedge clk);
        #1;
        cmd_valid = 1'b1;
        cmd_addr  = addr;
        cmd_len   = 16'(len);
        @(negedge clk);
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (cmd_ready) begin
            ok = 1;
        end else begin
            checks++;
            errors++;
            $display("[TB] FAIL cmd_accept: got cmd_ready 0 expected 1");
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic drive_words(input int len);
        int k = 0;
        @(posedge clk);
        #1;
        while (k < len && !timed_out) begin
            wdata_valid = ($urandom_range(0, 3) != 0);
            wdata       = words_q[k];
            @(negedge clk);
            if (!busy) break;
            if (wdata_valid && wdata_ready) begin
                words_acc++;
                k++;
            end
            @(posedge clk);
            #1;
        end
        wdata_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busy && n < IDLE_LIMIT) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            timed_out = 1;
            checks++;
            errors++;
            $display("[TB] FAIL idle_timeout: got busy 1 expected 0");
        end
    endtask

    task automatic run_cmd(input string tag, input logic [31:0] addr, input int len,
                           input int busy_at_word, input int busy_reps,
                           input int busy_poll, input int busy_poll_n,
                           input int err_poll, input bit rand_busy, input int exp_polls);
        int e_done;
        int e_err;
        int e_words;
        bit ok;
        build_model(addr, len, busy_at_word, busy_reps, busy_poll, busy_poll_n,
                    err_poll, rand_busy, e_done, e_err, e_words);
        done_seen  = 0;
        reads_seen = 0;
        words_acc  = 0;
        timed_out  = 0;
        apply_stimulus(addr, len, ok);
        if (ok) begin
            @(negedge clk);
            check_value({tag, ":err_cleared"}, err, 0);
            fork
                drive_words(len);
                wait_idle();
            join
            check_value({tag, ":done_count"}, done_seen, e_done);
            check_value({tag, ":err"}, err, e_err);
            check_value({tag, ":words_accepted"}, words_acc, e_words);
            check_value({tag, ":missing_reqs"}, exp_q.size(), 0);
            if (exp_polls >= 0) check_value({tag, ":polls"}, reads_seen, exp_polls);
        end
        exp_q.delete();
        plan_q.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check_value({tag, ":cmd_ready"}, cmd_ready, 0);
        check_value({tag, ":wdata_ready"}, wdata_ready, 0);
        check_value({tag, ":dmi_req_valid"}, dmi_req_valid, 0);
        check_value({tag, ":dmi_resp_ready"}, dmi_resp_ready, 0);
        check_value({tag, ":busy"}, busy, 0);
        check_value({tag, ":done"}, done, 0);
        check_value({tag, ":err"}, err, 0);
    endtask

    // Reset lands while the second data word's request is in flight
    task automatic reset_mid_transfer();
        int e_done;
        int e_err;
        int e_words;
        int base;
        bit ok;
        build_model(32'h0000_2000, 8, -1, 0, -1, 0, -1, 0, e_done, e_err, e_words);
        words_acc = 0;
        timed_out = 0;
        apply_stimulus(32'h0000_2000, 8, ok);
        fork
            drive_words(8);
            begin
                int n = 0;
                while (words_acc < 2 && n < IDLE_LIMIT) begin
                    @(posedge clk);
                    #2;
                    n++;
                end
                if (words_acc < 2) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL reset_wait: got %0d words expected 2", words_acc);
                end
                rst_n = 1'b0;
            end
        join
        @(negedge clk);
        check_reset_outputs("mid_reset");
        exp_q.delete();
        plan_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        base = reqs_seen;
        repeat (10) @(negedge clk);
        check_value("post_reset:reqs", reqs_seen, base);
        check_value("post_reset:busy", busy, 0);
        check_value("post_reset:cmd_ready", cmd_ready, 1);
    endtask

    initial begin
        rst_n       = 1'b0;
        cmd_valid   = 1'b0;
        cmd_addr    = 32'h0;
        cmd_len     = 16'h0;
        wdata_valid = 1'b0;
        wdata       = 32'h0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_value("reset:cmd_ready_after", cmd_ready, 1);

        run_cmd("basic",      32'h0000_1000,   4, -1, 0, -1,  0, -1, 0, 1);
        run_cmd("interval",   32'h0000_4000, 300, -1, 0, -1,  0, -1, 0, 3);
        run_cmd("exact_mult", 32'h0000_8000, 256, -1, 0, -1,  0, -1, 0, 2);
        run_cmd("data_busy",  32'h0000_0100,   4,  1, 2, -1,  0, -1, 0, 1);
        run_cmd("poll_busy15",32'h0000_0200,   5, -1, 0,  0, 15, -1, 0, 16);
        run_cmd("poll_limit", 32'h0000_0300,   3, -1, 0,  0, 16, -1, 0, 16);
        run_cmd("after_err",  32'h0000_0400,   2, -1, 0, -1,  0, -1, 0, 1);
        run_cmd("sberror",    32'h0000_0500, 200, -1, 0, -1,  0,  0, 0, 1);
        run_cmd("len_one",    32'h0000_0600,   1, -1, 0, -1,  0, -1, 0, 1);

        for (int i = 0; i < 5; i++) begin
            run_cmd("random", $urandom & 32'hFFFF_FFFC, $urandom_range(1, 300),
                    -1, 0, -1, 0, -1, 1, -1);
        end

        reset_mid_transfer();
        run_cmd("len_zero", 32'h0000_3000, 0, -1, 0, -1, 0, -1, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmi_sba_loader.md
DMI_SBA_LOADER -- requirements
Module: dmi_sba_loader

Interface
REQ-001 SHALL have parameter PollInterval, default 128: data words written between SBCS status polls.
REQ-002 SHALL have parameter MaxPolls, default 16: consecutive sbbusy polls tolerated before error.
REQ-003 SHALL have port clk  input  1  system clock.
REQ-004 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have ports cmd_valid/cmd_ready  input/output  1  load-command handshake.
REQ-006 SHALL have port cmd_addr  input  32  word-aligned target base address.
REQ-007 SHALL have port cmd_len  input  16  number of 32-bit words to load.
REQ-008 SHALL have ports wdata_valid/wdata_ready  input/output  1  word-stream handshake.
REQ-009 SHALL have port wdata  input  32  payload word.
REQ-010 SHALL have ports dmi_req_valid/dmi_req_ready  output/input  1  DMI request handshake.
REQ-011 SHALL have ports dmi_req_addr  output  7, dmi_req_op  output  2 (1 read, 2 write), dmi_req_data  output  32.
REQ-012 SHALL have ports dmi_resp_valid  input  1, dmi_resp_ready  output  1, dmi_resp_data  input  32, dmi_resp_op  input  2 (0 ok, 2 failed, 3 busy).
REQ-013 SHALL have ports busy  output  1, done  output  1 (one-cycle pulse), err  output  1 (sticky until next accepted command).

Function
REQ-014 SHALL implement FSM IDLE, WR_SBCS, WR_ADDR, WR_DATA, POLL, WAIT_RESP, DONE, ERR.
REQ-015 IDLE: cmd_ready=1; cmd handshake latches addr/len, clears err, enters WR_SBCS; cmd_len=0 goes directly to DONE with no DMI traffic.
REQ-016 WR_SBCS SHALL write SBCS (0x38) with 0x0005_8000 (sbaccess=2, sbautoincrement=1, sbreadondata=1).
REQ-017 WR_ADDR SHALL write SBAddress0 (0x39) with latched cmd_addr.
REQ-018 WR_DATA SHALL raise wdata_ready only when no DMI request is outstanding; each accepted word issues write SBData0 (0x3C) with that word.
REQ-019 At most one DMI request outstanding; every request waits in WAIT_RESP for its response before the next is issued; dmi_resp_ready=1 in WAIT_RESP only.
REQ-020 dmi_req_valid, addr, op, data SHALL remain stable from assertion until dmi_req_ready.
REQ-021 Response op 3 (busy) SHALL reissue the identical request; op 2 SHALL enter ERR; op 0 advances.
REQ-022 After every PollInterval-th data word and after the final word, SHALL enter POLL: read SBCS.
REQ-023 Poll result: sberror[14:12]!=0 or sbbusyerror[22]=1 -> ERR; sbbusy[21]=1 -> re-poll, incrementing poll counter; poll counter reaching MaxPolls -> ERR; else counter clears and loading resumes or finishes.
REQ-024 Word counter 16 bits; interval counter wraps to 0 at PollInterval; final-word poll not duplicated when len is a multiple of PollInterval.
REQ-025 DONE: done=1 for one cycle, return to IDLE next cycle.
REQ-026 ERR: err=1, abandon remaining words (wdata_ready=0), return to IDLE next cycle; err held until next cmd accepted.
REQ-027 busy=1 in every state except IDLE.
REQ-028 cmd_valid while busy SHALL be ignored (cmd_ready=0).

Reset
REQ-029 On rst_n low: state IDLE, all counters 0, cmd_ready=0 during reset then 1, wdata_ready=0, dmi_req_valid=0, dmi_resp_ready=0, busy=0, done=0, err=0.
REQ-030 Reset mid-transfer SHALL abort immediately with no further DMI request; outstanding response after reset is ignored.

Structure
REQ-031 DMI addresses (SBCS, SBAddress0, SBData0), op/resp encodings, SBCS bit positions and 0x0005_8000 init value SHALL live in the shared debug package, not locally.
REQ-032 Single module; no sub-module required.

Verification
REQ-033 cmd addr 0x0000_1000 len 4, responder always ok -> DMI sequence SBCS<=0x58000, SBAddress0<=0x1000, 4 SBData0 writes, 1 SBCS read, done pulse, err=0.
REQ-034 len 300, PollInterval 128 -> SBCS polls after words 128, 256, 300 exactly (3 polls).
REQ-035 Responder returns op 3 twice on 2nd data write -> same request reissued twice, data order intact, done.
REQ-036 SBCS poll returns sbbusy=1 16 times -> err=1, no done, IDLE; next command clears err.
REQ-037 Poll returns sberror=3'b010 -> err within one cycle, wdata_ready stays 0.
REQ-038 rst_n low during WR_DATA word 2 -> all outputs reset value, no further DMI requests; len 0 command -> done next cycle, zero DMI requests.
